// File: rtl/cp0_pkg.sv
// Shared definitions for the CP0 interrupt controller.
// Holds register numbers, field positions, exception codes, the handler entry
// address and helpers that assemble the SR and Cause read words.
package cp0_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NUM_IP  = 6;
  localparam int unsigned IP_LSB  = 10;
  localparam int unsigned BD_BIT  = 31;
  localparam int unsigned EXC_LSB = 2;
  localparam int unsigned EXL_BIT = 1;
  localparam int unsigned IE_BIT  = 0;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam logic [XLEN-1:0] HANDLER_ADDR = 32'h0000_4180;

  // SR read word: IM at [15:10], EXL at 1, IE at 0.
  function automatic logic [XLEN-1:0] pack_sr(input logic [NUM_IP-1:0] im,
                                              input logic exl, input logic ie);
    return {16'h0, im, 8'h0, exl, ie};
  endfunction

  // Cause read word: BD at 31, IP at [15:10], ExcCode at [6:2].
  function automatic logic [XLEN-1:0] pack_cause(input logic bd,
                                                 input logic [NUM_IP-1:0] ip,
                                                 input logic [4:0] exc);
    return {bd, 15'h0, ip, 3'h0, exc, 2'h0};
  endfunction

endpackage

// File: rtl/cp0_irq_capture.sv
// Per-line interrupt capture.
// Level lines follow hwint every cycle; edge lines latch on a rising edge and
// hold until cleared through w1c. A rising edge in the clear cycle wins.
// Ports: clk, clr (sync reset), hwint (device lines), w1c (qualified clear
// mask), ip (captured pending bits), ip_raw_c (next value ignoring w1c).
module cp0_irq_capture #(
  parameter int unsigned    W    = 6,
  parameter logic [W-1:0]   EDGE = '0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] hwint,
  input  logic [W-1:0] w1c,
  output logic [W-1:0] ip,
  output logic [W-1:0] ip_raw_c
);

  logic [W-1:0] hwint_d;
  logic [W-1:0] rise_c;
  logic [W-1:0] ip_next_c;

  assign rise_c = hwint & ~hwint_d;

  // ip_raw_c is independent of w1c so the interrupt decision does not loop
  // through the mtc0 suppression that gates the clear.
  assign ip_raw_c  = (EDGE & (ip | rise_c)) | (~EDGE & hwint);
  assign ip_next_c = (EDGE & ((ip & ~w1c) | rise_c)) | (~EDGE & hwint);

  always_ff @(posedge clk) begin
    if (clr) begin
      ip      <= '0;
      hwint_d <= '0;
    end else begin
      ip      <= ip_next_c;
      hwint_d <= hwint;
    end
  end

endmodule

// File: rtl/cp0_intc.sv
// Coprocessor-0 with integrated interrupt controller for the M stage.
// Ports: clk, clr (sync reset); we/addr/wd mtc0 write, rd mfc0 read data;
// pc/bd/exccode_in/exlclr from M; hwint device lines; intreq exception
// request; epc current EPC; exl SR.EXL.
// Optional macro CP0_TIMER_EN adds Count(9)/Compare(11) driving IP[15];
// NUM_HWINT must then be at most 5.
module cp0_intc
  import cp0_pkg::*;
#(
  parameter int unsigned NUM_HWINT = 6,
  parameter logic [5:0]  EDGE_MASK = 6'b000000,
  parameter logic [31:0] PRID_VAL  = 32'h0000_4D50
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 we,
  input  logic [4:0]           addr,
  input  logic [31:0]          wd,
  output logic [31:0]          rd,
  input  logic [31:0]          pc,
  input  logic                 bd,
  input  logic [4:0]           exccode_in,
  input  logic                 exlclr,
  input  logic [NUM_HWINT-1:0] hwint,
  output logic                 intreq,
  output logic [31:0]          epc,
  output logic                 exl
);

  localparam logic [5:0] LINE_MASK = 6'((7'd1 << NUM_HWINT) - 7'd1);
`ifdef CP0_TIMER_EN
  localparam logic [5:0] IM_WMASK = LINE_MASK | 6'b100000;
`else
  localparam logic [5:0] IM_WMASK = LINE_MASK;
`endif

  logic                 ie;
  logic                 exl_q;
  logic                 bd_q;
  logic [5:0]           im;
  logic [4:0]           exc_q;
  logic [31:0]          epc_q;
  logic [NUM_HWINT-1:0] line_ip;
  logic [NUM_HWINT-1:0] line_raw_c;
  logic [NUM_HWINT-1:0] line_w1c_c;
  logic [5:0]           ip;
  logic [5:0]           ip_raw_c;
  logic                 int_pend_c;
  logic                 exc_pend_c;
  logic                 mtc0_c;

  assign exl = exl_q;
  assign epc = epc_q;

  // A level line raises intreq in the same cycle because ip_raw_c is the
  // value being loaded, not the stored one.
  assign int_pend_c = ie & ~exl_q & |(ip_raw_c & im);
  assign exc_pend_c = ~exl_q & (exccode_in != 5'd0);
  assign intreq     = int_pend_c | exc_pend_c;
  // The M-stage instruction is cancelled when intreq fires.
  assign mtc0_c     = we & ~intreq;

  assign line_w1c_c = (mtc0_c && addr == REG_CAUSE) ? wd[IP_LSB +: NUM_HWINT]
                                                    : '0;

  cp0_irq_capture #(
    .W    (NUM_HWINT),
    .EDGE (EDGE_MASK[NUM_HWINT-1:0])
  ) u_capture (
    .clk      (clk),
    .clr      (clr),
    .hwint    (hwint),
    .w1c      (line_w1c_c),
    .ip       (line_ip),
    .ip_raw_c (line_raw_c)
  );

`ifdef CP0_TIMER_EN
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        tmr_ip;
  logic        tmr_hit_c;

  assign tmr_hit_c = (count_q == compare_q);
  assign ip        = 6'(line_ip) | {tmr_ip, 5'b0};
  assign ip_raw_c  = 6'(line_raw_c) | {tmr_ip | tmr_hit_c, 5'b0};

  // Free-running counter; a mtc0 write replaces the increment that cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      count_q   <= '0;
      compare_q <= '0;
      tmr_ip    <= 1'b0;
    end else begin
      count_q <= (mtc0_c && addr == REG_COUNT) ? wd : count_q + 32'd1;
      if (mtc0_c && addr == REG_COMPARE) compare_q <= wd;
      tmr_ip <= tmr_hit_c | (tmr_ip & ~(mtc0_c && addr == REG_COMPARE));
    end
  end
`else
  assign ip       = 6'(line_ip);
  assign ip_raw_c = 6'(line_raw_c);
`endif

  // SR, Cause and EPC state.
  always_ff @(posedge clk) begin
    if (clr) begin
      ie    <= 1'b0;
      exl_q <= 1'b0;
      im    <= '0;
      bd_q  <= 1'b0;
      exc_q <= '0;
      epc_q <= '0;
    end else if (intreq) begin
      exl_q <= 1'b1;
      exc_q <= int_pend_c ? EXC_INT : exccode_in;
      bd_q  <= bd;
      epc_q <= bd ? pc - 32'd4 : pc;
    end else begin
      if (exlclr) exl_q <= 1'b0;
      if (mtc0_c && addr == REG_SR) begin
        im    <= wd[IP_LSB +: 6] & IM_WMASK;
        exl_q <= wd[EXL_BIT];
        ie    <= wd[IE_BIT];
      end
      if (mtc0_c && addr == REG_EPC) epc_q <= wd & ~32'h3;
    end
  end

  // mfc0 read mux.
  always_comb begin
    rd = '0;
    case (addr)
      REG_SR:      rd = pack_sr(im, exl_q, ie);
      REG_CAUSE:   rd = pack_cause(bd_q, ip, exc_q);
      REG_EPC:     rd = epc_q;
      REG_PRID:    rd = PRID_VAL;
`ifdef CP0_TIMER_EN
      REG_COUNT:   rd = count_q;
      REG_COMPARE: rd = compare_q;
`endif
      default:     rd = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_intc.sv
// Self-checking bench for cp0_intc: directed scenarios plus a randomized run
// against a behavioural model of the CP0 register rules.
module tb_cp0_intc;

`ifdef CP0_TIMER_EN
  localparam int unsigned NH = 5;
`else
  localparam int unsigned NH = 6;
`endif
  localparam logic [5:0] EDGE = 6'b000010;
  localparam logic [5:0] IMW  = 6'h3F;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          we = 1'b0;
  logic [4:0]    addr = '0;
  logic [31:0]   wd = '0;
  logic [31:0]   rd;
  logic [31:0]   pc = '0;
  logic          bd = 1'b0;
  logic [4:0]    exccode_in = '0;
  logic          exlclr = 1'b0;
  logic [NH-1:0] hw = '0;
  logic          intreq;
  logic [31:0]   epc;
  logic          exl;

  int n_checks = 0;
  int n_errors = 0;

  // Model state.
  logic        m_ie, m_exl, m_bd;
  logic [5:0]  m_im, m_ip, m_hwd;
  logic [4:0]  m_exc;
  logic [31:0] m_epc, m_count, m_compare;

  cp0_intc #(.NUM_HWINT(NH), .EDGE_MASK(EDGE)) dut (
    .clk(clk), .clr(clr), .we(we), .addr(addr), .wd(wd), .rd(rd),
    .pc(pc), .bd(bd), .exccode_in(exccode_in), .exlclr(exlclr),
    .hwint(hw), .intreq(intreq), .epc(epc), .exl(exl)
  );

  always #5 clk = ~clk;

  // Pending bits as they would be loaded this cycle, before any software clear.
  function automatic logic [5:0] m_raw();
    logic [5:0] h, r;
    h = 6'(hw);
    r = 6'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < int'(NH)) r[i] = EDGE[i] ? (m_ip[i] | (h[i] & ~m_hwd[i])) : h[i];
    end
`ifdef CP0_TIMER_EN
    r[5] = m_ip[5] | (m_count == m_compare);
`endif
    return r;
  endfunction

  function automatic logic m_intpend();
    return m_ie && !m_exl && ((m_raw() & m_im) != 6'b0);
  endfunction

  function automatic logic m_intreq();
    return m_intpend() || (!m_exl && exccode_in != 5'd0);
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    case (a)
      5'd12: return {16'h0, m_im, 8'h0, m_exl, m_ie};
      5'd13: return {m_bd, 15'h0, m_ip, 3'h0, m_exc, 2'h0};
      5'd14: return m_epc;
      5'd15: return 32'h0000_4D50;
`ifdef CP0_TIMER_EN
      5'd9:  return m_count;
      5'd11: return m_compare;
`endif
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic m_step();
    logic [5:0] h, nip;
    logic ir, ipd, mt, hit;
    if (clr) begin
      m_ie = 0; m_exl = 0; m_bd = 0; m_im = 0; m_ip = 0; m_hwd = 0;
      m_exc = 0; m_epc = 0; m_count = 0; m_compare = 0;
      return;
    end
    h   = 6'(hw);
    ir  = m_intreq();
    ipd = m_intpend();
    mt  = we && !ir;
    hit = (m_count == m_compare);
    nip = 6'b0;
    for (int i = 0; i < int'(NH); i++) begin
      if (!EDGE[i]) nip[i] = h[i];
      else if (h[i] && !m_hwd[i]) nip[i] = 1'b1;
      else if (mt && addr == 5'd13 && wd[10+i]) nip[i] = 1'b0;
      else nip[i] = m_ip[i];
    end
`ifdef CP0_TIMER_EN
    nip[5] = hit || (m_ip[5] && !(mt && addr == 5'd11));
    if (mt && addr == 5'd11) m_compare = wd;
    m_count = (mt && addr == 5'd9) ? wd : m_count + 1;
`endif
    m_ip  = nip;
    m_hwd = h;
    if (ir) begin
      m_exl = 1;
      m_exc = ipd ? 5'd0 : exccode_in;
      m_bd  = bd;
      m_epc = bd ? pc - 4 : pc;
    end else begin
      if (exlclr) m_exl = 0;
      if (mt && addr == 5'd12) begin
        m_im = wd[15:10] & IMW; m_exl = wd[1]; m_ie = wd[0];
      end
      if (mt && addr == 5'd14) m_epc = {wd[31:2], 2'b00};
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic idle();
    we = 0; addr = 0; wd = 0; exccode_in = 0; exlclr = 0; clr = 0; bd = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1; addr = a; wd = d;
    cyc();
    we = 0;
  endtask

  task automatic do_reset();
    idle(); hw = '0; clr = 1;
    cyc();
    clr = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (intreq !== 1'b0) begin n_errors++; $display("FAIL reset_intreq: got %b exp 0", intreq); end
    n_checks++; if (exl !== 1'b0) begin n_errors++; $display("FAIL reset_exl: got %b exp 0", exl); end
    n_checks++; if (epc !== 32'h0) begin n_errors++; $display("FAIL reset_epc: got %h exp 0", epc); end
    addr = 5'd12; #1;
    n_checks++; if (rd !== 32'h0) begin n_errors++; $display("FAIL reset_sr: got %h exp 0", rd); end
    addr = 5'd13; #1;
    n_checks++; if (rd !== 32'h0) begin n_errors++; $display("FAIL reset_cause: got %h exp 0", rd); end
    addr = 5'd15; #1;
    n_checks++; if (rd !== 32'h0000_4D50) begin n_errors++; $display("FAIL prid: got %h exp 00004d50", rd); end
    addr = 5'd20; #1;
    n_checks++; if (rd !== 32'h0) begin n_errors++; $display("FAIL unmapped_read: got %h exp 0", rd); end
`ifndef CP0_TIMER_EN
    addr = 5'd9; #1;
    n_checks++; if (rd !== 32'h0) begin n_errors++; $display("FAIL count_absent: got %h exp 0", rd); end
    addr = 5'd11; #1;
    n_checks++; if (rd !== 32'h0) begin n_errors++; $display("FAIL compare_absent: got %h exp 0", rd); end
`endif
  endtask

  task automatic test_level_eret();
    do_reset();
    mtc0(5'd12, 32'h0000_0401);
    hw[0] = 1'b1; pc = 32'h3010; bd = 0; #1;
    n_checks++; if (intreq !== 1'b1) begin n_errors++; $display("FAIL level_intreq: got %b exp 1", intreq); end
    cyc();
    addr = 5'd13; #1;
    n_checks++; if (rd !== 32'h0000_0400) begin n_errors++; $display("FAIL level_cause: got %h exp 00000400", rd); end
    n_checks++; if (epc !== 32'h3010) begin n_errors++; $display("FAIL level_epc: got %h exp 00003010", epc); end
    n_checks++; if (exl !== 1'b1) begin n_errors++; $display("FAIL level_exl: got %b exp 1", exl); end
    n_checks++; if (intreq !== 1'b0) begin n_errors++; $display("FAIL level_masked_by_exl: got %b exp 0", intreq); end
    exlclr = 1; #1;
    n_checks++; if (intreq !== 1'b0) begin n_errors++; $display("FAIL eret_cycle_intreq: got %b exp 0", intreq); end
    cyc();
    exlclr = 0; #1;
    n_checks++; if (exl !== 1'b0) begin n_errors++; $display("FAIL eret_exl: got %b exp 0", exl); end
    n_checks++; if (intreq !== 1'b1) begin n_errors++; $display("FAIL eret_refire: got %b exp 1", intreq); end
    cyc();
    n_checks++; if (exl !== 1'b1) begin n_errors++; $display("FAIL refire_exl: got %b exp 1", exl); end
    clr = 1; hw = '0;
    cyc();
    clr = 0;
    addr = 5'd12; #1;
    n_checks++; if (rd !== 32'h0) begin n_errors++; $display("FAIL midreset_sr: got %h exp 0", rd); end
    addr = 5'd13; #1;
    n_checks++; if (rd !== 32'h0) begin n_errors++; $display("FAIL midreset_cause: got %h exp 0", rd); end
    addr = 5'd14; #1;
    n_checks++; if (rd !== 32'h0) begin n_errors++; $display("FAIL midreset_epc: got %h exp 0", rd); end
  endtask

  task automatic test_edge_w1c();
    do_reset();
    hw[1] = 1'b1;
    cyc();
    hw[1] = 1'b0;
    addr = 5'd13;
    for (int k = 0; k < 12; k++) begin
      cyc();
      n_checks++; if (rd[11] !== 1'b1) begin n_errors++; $display("FAIL edge_hold[%0d]: got %b exp 1", k, rd[11]); end
    end
    mtc0(5'd13, 32'h0000_0800);
    addr = 5'd13; #1;
    n_checks++; if (rd[11] !== 1'b0) begin n_errors++; $display("FAIL edge_w1c: got %b exp 0", rd[11]); end
    we = 1; wd = 32'h0000_0800; hw[1] = 1'b1;
    cyc();
    we = 0; #1;
    n_checks++; if (rd[11] !== 1'b1) begin n_errors++; $display("FAIL edge_wins_clear: got %b exp 1", rd[11]); end
    hw[1] = 1'b0;
  endtask

  task automatic test_delay_slot();
    do_reset();
    exccode_in = 5'd12; bd = 1; pc = 32'h3024; #1;
    n_checks++; if (intreq !== 1'b1) begin n_errors++; $display("FAIL exc_intreq: got %b exp 1", intreq); end
    cyc();
    exccode_in = 0; bd = 0; addr = 5'd13; #1;
    n_checks++; if (epc !== 32'h3020) begin n_errors++; $display("FAIL bd_epc: got %h exp 00003020", epc); end
    n_checks++; if (rd !== 32'h8000_0030) begin n_errors++; $display("FAIL bd_cause: got %h exp 80000030", rd); end
    exccode_in = 5'd5; pc = 32'h4000; #1;
    n_checks++; if (intreq !== 1'b0) begin n_errors++; $display("FAIL nested_exc: got %b exp 0", intreq); end
    cyc();
    exccode_in = 0; #1;
    n_checks++; if (rd !== 32'h8000_0030) begin n_errors++; $display("FAIL nested_cause: got %h exp 80000030", rd); end
  endtask

  task automatic test_priority();
    do_reset();
    mtc0(5'd12, 32'h0000_0401);
    hw[0] = 1'b1; exccode_in = 5'd4; pc = 32'h3100; bd = 0;
    we = 1; addr = 5'd14; wd = 32'h5000; #1;
    n_checks++; if (intreq !== 1'b1) begin n_errors++; $display("FAIL prio_intreq: got %b exp 1", intreq); end
    cyc();
    we = 0; exccode_in = 0; addr = 5'd13; #1;
    n_checks++; if (rd[6:2] !== 5'd0) begin n_errors++; $display("FAIL prio_exccode: got %0d exp 0", rd[6:2]); end
    n_checks++; if (epc !== 32'h3100) begin n_errors++; $display("FAIL suppress_epc: got %h exp 00003100", epc); end
    hw[0] = 1'b0;
  endtask

`ifdef CP0_TIMER_EN
  task automatic test_timer();
    bit seen = 0;
    do_reset();
    mtc0(5'd9, 32'd100);
    mtc0(5'd11, 32'd20);
    mtc0(5'd9, 32'd0);
    mtc0(5'd12, 32'h0000_8001);
    addr = 5'd9;
    for (int k = 0; k < 60 && !seen; k++) begin
      #1;
      if (intreq === 1'b1) seen = 1;
      else cyc();
    end
    n_checks++; if (!seen) begin n_errors++; $display("FAIL timer_timeout: got no intreq exp intreq"); end
    n_checks++; if (rd !== 32'd20) begin n_errors++; $display("FAIL timer_count: got %0d exp 20", rd); end
    cyc();
    addr = 5'd13; #1;
    n_checks++; if (rd[15] !== 1'b1) begin n_errors++; $display("FAIL timer_ip: got %b exp 1", rd[15]); end
    mtc0(5'd11, 32'd1000);
    addr = 5'd13; #1;
    n_checks++; if (rd[15] !== 1'b0) begin n_errors++; $display("FAIL timer_clear: got %b exp 0", rd[15]); end
  endtask
`endif

  task automatic test_random();
    logic [4:0] regs [7];
    regs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
    do_reset();
    for (int k = 0; k < 400; k++) begin
      idle();
      clr = ($urandom_range(0, 49) == 0);
      we  = ($urandom_range(0, 3) == 0);
      addr = regs[$urandom_range(0, 6)];
      wd  = $urandom;
      if ($urandom_range(0, 3) == 0) hw = hw ^ NH'($urandom);
      if ($urandom_range(0, 7) == 0) exccode_in = 5'($urandom_range(1, 31));
      if (!we && m_exl && $urandom_range(0, 3) == 0) exlclr = 1;
      bd = 1'($urandom);
      pc = {$urandom, 2'b00};
      #1;
      n_checks++; if (intreq !== m_intreq()) begin n_errors++; $display("FAIL rand_intreq[%0d]: got %b exp %b", k, intreq, m_intreq()); end
      n_checks++; if (rd !== m_rd(addr)) begin n_errors++; $display("FAIL rand_rd[%0d] addr %0d: got %h exp %h", k, addr, rd, m_rd(addr)); end
      cyc();
      n_checks++; if (exl !== m_exl) begin n_errors++; $display("FAIL rand_exl[%0d]: got %b exp %b", k, exl, m_exl); end
      n_checks++; if (epc !== m_epc) begin n_errors++; $display("FAIL rand_epc[%0d]: got %h exp %h", k, epc, m_epc); end
    end
    idle(); hw = '0;
  endtask

  initial begin
    #1;
    test_reset();
    test_level_eret();
    test_edge_w1c();
    test_delay_slot();
    test_priority();
`ifdef CP0_TIMER_EN
    test_timer();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
